// File: rtl/value_sequence_generator.sv
// value_sequence_generator
// Emits a stream of W-bit values over a valid/ready handshake. A sequence is
// started from IDLE with `start`. Its mode and length are captured at that
// moment. The generator then produces a constant, an up ramp, a down ramp, or
// an alternating VALUE/~VALUE pattern. A length of zero makes the sequence run
// until `clear` or `reset`.
//
// Optional build macro: VALUE_SEQUENCE_GENERATOR_SATURATE_EN
//   When defined, the up ramp clamps at all-ones and the down ramp clamps at
//   zero instead of wrapping modulo 2^W.
module value_sequence_generator #(
  parameter int          W     = 32,
  parameter int unsigned VALUE = 5,
  parameter int unsigned STEP  = 1,
  parameter int          LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] length,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             busy,
  output logic             done
);

  // Parameter values brought to the datapath width once, so every
  // comparison and arithmetic operation below is W bits wide.
  localparam logic [W-1:0] SEED_C = W'(VALUE);
  localparam logic [W-1:0] INC_C  = W'(STEP);
  localparam logic [W-1:0] ONES_C = {W{1'b1}};
  localparam logic [W-1:0] ZERO_C = {W{1'b0}};

  localparam logic [1:0] MODE_CONST = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_ALT   = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [1:0]       mode_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic             out_valid_r;
  logic [W-1:0]     out_data_r;
  logic             done_r;

  logic             xfer_s;
  logic [LEN_W-1:0] cnt_next_s;
  logic             last_s;
  logic [W-1:0]     data_next_s;

  // Successor of the current output value for the latched mode.
  function automatic logic [W-1:0] next_value(input logic [1:0] m,
                                              input logic [W-1:0] cur);
    logic [W-1:0] res;
`ifdef VALUE_SEQUENCE_GENERATOR_SATURATE_EN
    logic [W:0] sum;
    sum = {1'b0, cur} + {1'b0, INC_C};
`endif
    case (m)
      MODE_CONST: res = SEED_C;
`ifdef VALUE_SEQUENCE_GENERATOR_SATURATE_EN
      // A carry out of the top bit means the ramp would pass all-ones.
      MODE_UP:    res = sum[W] ? ONES_C : sum[W-1:0];
      // Borrow detection: anything below STEP would go under zero.
      MODE_DOWN:  res = (cur < INC_C) ? ZERO_C : (cur - INC_C);
`else
      MODE_UP:    res = cur + INC_C;
      MODE_DOWN:  res = cur - INC_C;
`endif
      // Every sequence starts at VALUE, so comparing against it is enough to
      // know which half of the toggle comes next.
      MODE_ALT:   res = (cur == SEED_C) ? ~SEED_C : SEED_C;
      default:    res = SEED_C;
    endcase
    return res;
  endfunction

  // Handshake decode, transfer counting, and end-of-sequence detection.
  always_comb begin
    xfer_s      = out_valid_r & out_ready;
    cnt_next_s  = cnt_r + LEN_W'(1'b1);
    data_next_s = next_value(mode_r, out_data_r);
    if (len_r != {LEN_W{1'b0}}) begin
      last_s = (cnt_next_s == len_r);
    end else begin
      last_s = 1'b0;
    end
  end

  // Control FSM with registered data, valid, and done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_CONST;
      len_r       <= {LEN_W{1'b0}};
      cnt_r       <= {LEN_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= ZERO_C;
      done_r      <= 1'b0;
    end else if (clear) begin
      // Clear overrides start and any pending transfer in the same cycle.
      state_r     <= ST_IDLE;
      cnt_r       <= {LEN_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= ZERO_C;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_r      <= mode;
            len_r       <= length;
            cnt_r       <= {LEN_W{1'b0}};
            out_data_r  <= SEED_C;
            out_valid_r <= 1'b1;
            state_r     <= ST_RUN;
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        ST_RUN: begin
          // With no transfer, everything holds, which keeps the
          // stalled output stable.
          if (xfer_s) begin
            cnt_r <= cnt_next_s;
            if (last_s) begin
              // Leave out_data at the last value so it stays visible.
              state_r     <= ST_IDLE;
              out_valid_r <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              out_data_r <= data_next_s;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = (state_r == ST_RUN);
  assign done      = done_r;

endmodule

// File: tb/tb_value_sequence_generator.sv
// Self-checking bench for value_sequence_generator.
// dut_a: W=8, VALUE=5,   STEP=1
// dut_b: W=8, VALUE=250, STEP=3
// Expected values are queued when a sequence is started. They are popped as
// transfers occur. Samples are taken on the falling clock edge.
module tb_value_sequence_generator;

  logic       clk;
  logic       reset;

  logic       clear_a, start_a, ready_a;
  logic [1:0] mode_a;
  logic [7:0] length_a;
  logic       out_valid_a, busy_a, done_a;
  logic [7:0] out_data_a;

  logic       clear_b, start_b, ready_b;
  logic [1:0] mode_b;
  logic [7:0] length_b;
  logic       out_valid_b, busy_b, done_b;
  logic [7:0] out_data_b;

  int n_vec;
  int n_miss;
  logic [7:0] exp_q[$];

  value_sequence_generator #(.W(8), .VALUE(5), .STEP(1), .LEN_W(8)) dut_a (
    .clk(clk), .reset(reset), .clear(clear_a), .start(start_a),
    .mode(mode_a), .length(length_a), .out_ready(ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .busy(busy_a),
    .done(done_a)
  );

  value_sequence_generator #(.W(8), .VALUE(250), .STEP(3), .LEN_W(8)) dut_b (
    .clk(clk), .reset(reset), .clear(clear_b), .start(start_b),
    .mode(mode_b), .length(length_b), .out_ready(ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .busy(busy_b),
    .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_vec++;
    if ({out_valid_a, busy_a, done_a, out_data_a} !== 11'd0) begin
      n_miss++;
      $display("FAIL reset_a: got v=%b b=%b d=%b data=%0d, want all zero",
               out_valid_a, busy_a, done_a, out_data_a);
    end
    n_vec++;
    if ({out_valid_b, busy_b, done_b, out_data_b} !== 11'd0) begin
      n_miss++;
      $display("FAIL reset_b: got v=%b b=%b d=%b data=%0d, want all zero",
               out_valid_b, busy_b, done_b, out_data_b);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_constant();
    exp_q.delete();
    @(negedge clk);
    start_a = 1'b1; mode_a = 2'b00; length_a = 8'd3; ready_a = 1'b1;
    repeat (3) exp_q.push_back(8'd5);
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_vec++;
      if ({done_a, out_valid_a, out_data_a} !== {1'b0, 1'b1, exp_q[0]}) begin
        n_miss++;
        $display("FAIL const_data: got d=%b v=%b data=%0d, want d=0 v=1 data=%0d",
                 done_a, out_valid_a, out_data_a, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    n_vec++;
    if ({done_a, out_valid_a, busy_a, out_data_a} !== {3'b100, 8'd5}) begin
      n_miss++;
      $display("FAIL const_done: got d=%b v=%b b=%b data=%0d, want d=1 v=0 b=0 data=5",
               done_a, out_valid_a, busy_a, out_data_a);
    end
    @(negedge clk);
    n_vec++;
    if ({done_a, out_valid_a} !== 2'b00) begin
      n_miss++;
      $display("FAIL const_done_pulse: got d=%b v=%b, want 0 0", done_a, out_valid_a);
    end
  endtask

  task automatic test_ramp_up();
    exp_q.delete();
    @(negedge clk);
    start_b = 1'b1; mode_b = 2'b01; length_b = 8'd4; ready_b = 1'b1;
`ifdef VALUE_SEQUENCE_GENERATOR_SATURATE_EN
    exp_q.push_back(8'd250); exp_q.push_back(8'd253);
    exp_q.push_back(8'd255); exp_q.push_back(8'd255);
`else
    exp_q.push_back(8'd250); exp_q.push_back(8'd253);
    exp_q.push_back(8'd0);   exp_q.push_back(8'd3);
`endif
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      start_b = 1'b0;
      n_vec++;
      if ({done_b, out_valid_b, out_data_b} !== {1'b0, 1'b1, exp_q[0]}) begin
        n_miss++;
        $display("FAIL ramp_up_data: got d=%b v=%b data=%0d, want d=0 v=1 data=%0d",
                 done_b, out_valid_b, out_data_b, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    n_vec++;
    if ({done_b, out_valid_b, busy_b} !== 3'b100) begin
      n_miss++;
      $display("FAIL ramp_up_done: got d=%b v=%b b=%b, want 1 0 0",
               done_b, out_valid_b, busy_b);
    end
  endtask

  task automatic test_stall_down();
    exp_q.delete();
    @(negedge clk);
    start_a = 1'b1; mode_a = 2'b10; length_a = 8'd4; ready_a = 1'b0;
    exp_q.push_back(8'd5); exp_q.push_back(8'd4);
    exp_q.push_back(8'd3); exp_q.push_back(8'd2);
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      start_a  = 1'b0;
      // Changing mode/length mid-sequence must not affect the sequence.
      mode_a   = 2'b01;
      length_a = 8'd0;
      ready_a  = (cyc >= 2);
      n_vec++;
      if ({done_a, out_valid_a, out_data_a} !== {1'b0, 1'b1, exp_q[0]}) begin
        n_miss++;
        $display("FAIL stall_data: cyc=%0d got d=%b v=%b data=%0d, want d=0 v=1 data=%0d",
                 cyc, done_a, out_valid_a, out_data_a, exp_q[0]);
      end
      if (ready_a) void'(exp_q.pop_front());
    end
    @(negedge clk);
    n_vec++;
    if ({done_a, out_valid_a, busy_a, out_data_a} !== {3'b100, 8'd2}) begin
      n_miss++;
      $display("FAIL stall_done: got d=%b v=%b b=%b data=%0d, want 1 0 0 data=2",
               done_a, out_valid_a, busy_a, out_data_a);
    end
  endtask

  task automatic test_alternate_clear();
    exp_q.delete();
    @(negedge clk);
    start_a = 1'b1; mode_a = 2'b11; length_a = 8'd0; ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h05);
      exp_q.push_back(8'hFA);
    end
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_vec++;
      if ({done_a, out_valid_a, out_data_a} !== {1'b0, 1'b1, exp_q[0]}) begin
        n_miss++;
        $display("FAIL alt_data: got d=%b v=%b data=%h, want d=0 v=1 data=%h",
                 done_a, out_valid_a, out_data_a, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    n_vec++;
    if ({busy_a, out_valid_a, done_a} !== 3'b110) begin
      n_miss++;
      $display("FAIL alt_continuous: got b=%b v=%b d=%b, want 1 1 0",
               busy_a, out_valid_a, done_a);
    end
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    n_vec++;
    if ({out_valid_a, busy_a, done_a, out_data_a} !== 11'd0) begin
      n_miss++;
      $display("FAIL alt_clear: got v=%b b=%b d=%b data=%0d, want all zero",
               out_valid_a, busy_a, done_a, out_data_a);
    end
    @(negedge clk);
    n_vec++;
    if ({out_valid_a, done_a} !== 2'b00) begin
      n_miss++;
      $display("FAIL alt_clear_no_done: got v=%b d=%b, want 0 0", out_valid_a, done_a);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start_a = 1'b1; mode_a = 2'b01; length_a = 8'd0; ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy_a, out_valid_a, out_data_a} !== {2'b11, 8'd6}) begin
      n_miss++;
      $display("FAIL midrun_pre: got b=%b v=%b data=%0d, want 1 1 data=6",
               busy_a, out_valid_a, out_data_a);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({out_valid_a, busy_a, done_a, out_data_a} !== 11'd0) begin
      n_miss++;
      $display("FAIL midrun_async: got v=%b b=%b d=%b data=%0d, want all zero",
               out_valid_a, busy_a, done_a, out_data_a);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({out_valid_a, busy_a, done_a} !== 3'b000) begin
      n_miss++;
      $display("FAIL midrun_after: got v=%b b=%b d=%b, want 0 0 0",
               out_valid_a, busy_a, done_a);
    end
    start_a = 1'b1; mode_a = 2'b00; length_a = 8'd0;
    @(negedge clk);
    start_a = 1'b0;
    n_vec++;
    if ({out_valid_a, busy_a, out_data_a} !== {2'b11, 8'd5}) begin
      n_miss++;
      $display("FAIL midrun_restart: got v=%b b=%b data=%0d, want 1 1 data=5",
               out_valid_a, busy_a, out_data_a);
    end
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
  endtask

  task automatic test_start_clear();
    @(negedge clk);
    start_a = 1'b1; clear_a = 1'b1; mode_a = 2'b00; length_a = 8'd2; ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; clear_a = 1'b0;
    n_vec++;
    if ({out_valid_a, busy_a, done_a, out_data_a} !== 11'd0) begin
      n_miss++;
      $display("FAIL start_clear: got v=%b b=%b d=%b data=%0d, want all zero",
               out_valid_a, busy_a, done_a, out_data_a);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    @(negedge clk);
    start_a = 1'b1; mode_a = 2'b00; length_a = 8'd1; ready_a = 1'b1;
    exp_q.push_back(8'd5);
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_vec++;
      if ({out_valid_a, out_data_a} !== {1'b1, exp_q[0]}) begin
        n_miss++;
        $display("FAIL b2b_first: got v=%b data=%0d, want v=1 data=%0d",
                 out_valid_a, out_data_a, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    n_vec++;
    if ({done_a, out_valid_a} !== 2'b10) begin
      n_miss++;
      $display("FAIL b2b_done: got d=%b v=%b, want 1 0", done_a, out_valid_a);
    end
    start_a = 1'b1; mode_a = 2'b01; length_a = 8'd2;
    exp_q.push_back(8'd5); exp_q.push_back(8'd6);
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_vec++;
      if ({done_a, out_valid_a, out_data_a} !== {1'b0, 1'b1, exp_q[0]}) begin
        n_miss++;
        $display("FAIL b2b_second: got d=%b v=%b data=%0d, want d=0 v=1 data=%0d",
                 done_a, out_valid_a, out_data_a, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    n_vec++;
    if ({done_a, out_valid_a, out_data_a} !== {2'b10, 8'd6}) begin
      n_miss++;
      $display("FAIL b2b_second_done: got d=%b v=%b data=%0d, want 1 0 data=6",
               done_a, out_valid_a, out_data_a);
    end
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    reset = 1'b1;
    clear_a = 1'b0; start_a = 1'b0; ready_a = 1'b0; mode_a = 2'b00; length_a = 8'd0;
    clear_b = 1'b0; start_b = 1'b0; ready_b = 1'b0; mode_b = 2'b00; length_b = 8'd0;
    test_reset();
    test_constant();
    test_ramp_up();
    test_stall_down();
    test_alternate_clear();
    test_reset_midrun();
    test_start_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
